// File: rtl/fpu_divide_iterate.sv
// ============================================================================
//  Module   : fpu_divide_iterate
//  Purpose  : Mantissa iteration stage of the floating-point divider. Takes
//             the dividend (a) and divisor (b) from the exponent stage and
//             runs ITERATIONS restoring-division steps, building the
//             quotient in y. Sign, special-case flags, exponent and mode
//             pass through unchanged to the normalize stage.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             in_valid/ready  - upstream handshake, in_data operands
//             out_valid/ready - downstream handshake, out_data result
//             busy            - high whenever an operation is held
//  Options  : FPU_DIVIDE_SPECIAL_BYPASS_EN - when defined, operands flagged
//             nan/inf/zero skip iteration and finish straight away with y=0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fpu_div_pkg;
    localparam int EXP_W  = 12;
    localparam int Y_W    = 27;
    localparam int AB_W   = 51;

    typedef struct packed {
        logic              sign;
        logic              nan;
        logic              inf;
        logic              zero;
        logic [EXP_W-1:0]  exponent;
        logic              exp_neg;
        logic              valid;
        logic [1:0]        mode;
        logic [Y_W-1:0]    y;       // quotient bits, MSB first
        logic [AB_W-1:0]   a;       // partial remainder
        logic [AB_W-1:0]   b;       // divisor, shifted right each step
    } fpu_div_result_t;
endpackage

module fpu_divide_iterate
    import fpu_div_pkg::*;
#(
    parameter int ITERATIONS = 27
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [$bits(fpu_div_result_t)-1:0]  in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [$bits(fpu_div_result_t)-1:0]  out_data,
    output logic                                busy
);

    localparam int CNT_W = $clog2(ITERATIONS + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(ITERATIONS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ITER = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    logic [CNT_W-1:0] count;
    fpu_div_result_t data;

    fpu_div_result_t in_op;
    fpu_div_result_t captured;
    fpu_div_result_t stepped;
    logic            b_fits;
    logic            special;

    assign in_op = fpu_div_result_t'(in_data);

`ifdef FPU_DIVIDE_SPECIAL_BYPASS_EN
    // Special operands have a quotient decided elsewhere; no point iterating.
    assign special = in_op.nan | in_op.inf | in_op.zero;
`else
    assign special = 1'b0;
`endif

    // Quotient accumulator always starts clean regardless of upstream contents.
    always_comb begin
        captured   = in_op;
        captured.y = '0;
    end

    // One restoring step: unsigned compare, subtract only when b fits, so the
    // remainder can never go negative and no restore cycle is needed.
    always_comb begin
        stepped   = data;
        b_fits    = (data.b <= data.a);
        stepped.y = {data.y[Y_W-2:0], b_fits};
        if (b_fits) begin
            stepped.a = data.a - data.b;
        end
        stepped.b = data.b >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
            data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        data  <= captured;
                        count <= '0;
                        state <= special ? DONE : ITER;
                    end
                end
                ITER: begin
                    data  <= stepped;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // data is untouched here, so it holds under backpressure
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = data;

endmodule

`default_nettype wire

// File: tb/tb_fpu_divide_iterate.sv
`default_nettype none

module tb_fpu_divide_iterate;
    import fpu_div_pkg::*;

    localparam int ITER = 27;
    localparam int W    = $bits(fpu_div_result_t);

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    fpu_div_result_t in_data;
    logic            out_valid;
    logic            out_ready;
    logic [W-1:0]    out_data_raw;
    fpu_div_result_t out_data;
    logic            busy;

    assign out_data = fpu_div_result_t'(out_data_raw);

    always #5 clk = ~clk;

    fpu_divide_iterate #(.ITERATIONS(ITER)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data_raw),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    typedef struct {
        string           name;
        fpu_div_result_t op;
        logic [26:0]     exp_y;
        logic [50:0]     exp_a;
        logic [50:0]     exp_b;
        int              exp_lat;
    } vec_t;

    vec_t vecs[6];

    function automatic fpu_div_result_t mk(input logic [50:0] a, input logic [50:0] b,
                                           input logic sign, input logic zero,
                                           input logic [11:0] e, input logic [1:0] mode);
        fpu_div_result_t r;
        r          = '0;
        r.a        = a;
        r.b        = b;
        r.sign     = sign;
        r.zero     = zero;
        r.exponent = e;
        r.exp_neg  = sign;
        r.valid    = 1'b1;
        r.mode     = mode;
        r.y        = 27'h5A5A5A5;   // garbage: must be cleared on capture
        return r;
    endfunction

    // Issue one operation, measure edges from the accepting edge (counted as
    // edge 1) until out_valid, optionally complete the output handshake.
    task automatic issue(input fpu_div_result_t d, input bit handshake,
                         output int lat, output fpu_div_result_t res);
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = '1;
        lat = 1;
        while (!out_valid && lat < 100) begin
            if (lat == 2) begin
                chk("iter_out_valid", 256'(out_valid), 256'(0));
                chk("iter_busy",      256'(busy),      256'(1));
                chk("iter_in_ready",  256'(in_ready),  256'(0));
            end
            @(posedge clk);
            #1;
            lat++;
        end
        res = out_data;
        if (handshake) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk("handshake_idle", 256'({in_ready, out_valid, busy}), 256'(3'b100));
        end
    endtask

    initial begin
        int              lat;
        int              seen;
        fpu_div_result_t res;
        fpu_div_result_t exp;
        fpu_div_result_t held;

        vecs[0] = '{"1.0/1.0",  mk(51'h1 << 49, 51'h1 << 49, 1'b0, 1'b0, 12'h3FF, 2'b00),
                    27'h4000000, 51'h0, 51'h1 << 22, ITER + 1};
        vecs[1] = '{"1.5/1.0",  mk(51'h3 << 48, 51'h1 << 49, 1'b0, 1'b0, 12'h400, 2'b01),
                    27'h6000000, 51'h0, 51'h1 << 22, ITER + 1};
        vecs[2] = '{"1.0/1.5",  mk(51'h1 << 49, 51'h3 << 48, 1'b1, 1'b0, 12'h3FF, 2'b10),
                    27'h2AAAAAA, 51'h1 << 23, 51'h3 << 21, ITER + 1};
        vecs[3] = '{"1.75/1.0", mk(51'h7 << 47, 51'h1 << 49, 1'b0, 1'b0, 12'h123, 2'b11),
                    27'h7000000, 51'h0, 51'h1 << 22, ITER + 1};
        vecs[4] = '{"a_zero",   mk(51'h0, 51'h1 << 49, 1'b0, 1'b0, 12'h001, 2'b00),
                    27'h0, 51'h0, 51'h1 << 22, ITER + 1};
        vecs[5] = '{"zero_flag", mk(51'h1 << 49, 51'h1 << 49, 1'b1, 1'b1, 12'h0AB, 2'b01),
                    27'h4000000, 51'h0, 51'h1 << 22, ITER + 1};
`ifdef FPU_DIVIDE_SPECIAL_BYPASS_EN
        vecs[5].exp_y   = 27'h0;
        vecs[5].exp_a   = 51'h1 << 49;
        vecs[5].exp_b   = 51'h1 << 49;
        vecs[5].exp_lat = 1;
`endif

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 256'(out_valid),    256'(0));
        chk("rst_busy",      256'(busy),         256'(0));
        chk("rst_in_ready",  256'(in_ready),     256'(1));
        chk("rst_out_data",  256'(out_data_raw), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // Table-driven functional vectors
        for (int i = 0; i < 6; i++) begin
            issue(vecs[i].op, 1'b1, lat, res);
            exp   = vecs[i].op;
            exp.y = vecs[i].exp_y;
            exp.a = vecs[i].exp_a;
            exp.b = vecs[i].exp_b;
            chk({vecs[i].name, "_latency"}, 256'(lat), 256'(vecs[i].exp_lat));
            chk({vecs[i].name, "_y"},       256'(res.y), 256'(vecs[i].exp_y));
            chk({vecs[i].name, "_a"},       256'(res.a), 256'(vecs[i].exp_a));
            chk({vecs[i].name, "_all"},     256'(res),   256'(exp));
        end
        chk("1.0/1.5_a_nonzero", 256'(vecs[2].exp_a != 0), 256'(1));

        // Backpressure: hold DONE five cycles while in_valid pulses
        issue(vecs[0].op, 1'b0, lat, held);
        chk("bp_latency", 256'(lat), 256'(ITER + 1));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = k[0];
            in_data  = vecs[2].op;
            @(posedge clk);
            #1;
            chk("bp_out_data_stable", 256'(out_data_raw), 256'(held));
            chk("bp_in_ready",        256'(in_ready),     256'(0));
            chk("bp_out_valid",       256'(out_valid),    256'(1));
        end
        @(negedge clk);
        in_valid  = 1'b1;   // offered during the handshake cycle: must be ignored
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_idle", 256'({in_ready, out_valid, busy}), 256'(3'b100));
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("bp_no_stray_capture", 256'(busy), 256'(0));

        // Reset in the middle of iteration
        @(negedge clk);
        in_data  = vecs[1].op;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst       = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_state", 256'({in_ready, out_valid, busy}), 256'(3'b100));
        chk("midrst_data",  256'(out_data_raw), 256'(0));
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (ITER + 5) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        out_ready = 1'b0;
        chk("midrst_discarded", 256'(seen), 256'(0));
        issue(vecs[2].op, 1'b1, lat, res);
        chk("post_rst_latency", 256'(lat),   256'(ITER + 1));
        chk("post_rst_y",       256'(res.y), 256'(27'h2AAAAAA));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/fpu_divide_iterate.md
FPU_DIVIDE_ITERATE -- requirements
Module: fpu_divide_iterate

Interface
REQ-001 SHALL have parameter ITERATIONS, default 27, meaning the number of restoring-division steps per operation; legal range 1..27.
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_valid  input  1  upstream (exponent stage) has an operation on in_data.
REQ-005 SHALL have port in_ready  output  1  block accepts in_data this cycle.
REQ-006 SHALL have port in_data  input  $bits(fpu_div_result_t)  operands and flags from the exponent stage.
REQ-007 SHALL have port out_valid  output  1  out_data holds a finished quotient for the normalize stage.
REQ-008 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-009 SHALL have port out_data  output  $bits(fpu_div_result_t)  iterated result: final y, A remainder, b, and pass-through fields.
REQ-010 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, ITER, DONE; in_ready = 1 only in IDLE.
REQ-012 IDLE: on in_valid && in_ready, register in_data with y forced to 0, clear step counter, go to ITER.
REQ-013 ITER: each cycle apply one restoring step: y <= y<<1; if b <= A then A <= A-b and y[0] <= 1, else y[0] <= 0; b <= b>>1.
REQ-014 ITER: step counter width $clog2(ITERATIONS+1); increments once per step; after the step with counter == ITERATIONS-1, go to DONE.
REQ-015 sign, nan, inf, zero, exponent, exp_neg, valid, mode SHALL pass from captured in_data to out_data unchanged.
REQ-016 DONE: out_valid = 1; out_data SHALL be stable while out_valid && !out_ready.
REQ-017 DONE: on out_ready, go to IDLE; no input is accepted in the handshake cycle, so the minimum issue interval is ITERATIONS+2 cycles.
REQ-018 Latency: out_valid SHALL first be high ITERATIONS+1 rising edges after the accepting edge (28 for default).
REQ-019 in_valid while not IDLE SHALL be ignored; in_data is not sampled.
REQ-020 out_valid SHALL be 0 in IDLE and ITER; out_ready outside DONE has no effect.
REQ-021 Comparison and subtraction SHALL be unsigned, full 51-bit; A never goes negative.

Reset
REQ-022 rst high at an edge SHALL force IDLE, counter 0, out_valid 0, busy 0, in_ready 1 after that edge, regardless of state.
REQ-023 An operation in flight during reset SHALL be discarded with no output.
REQ-024 The out_data register SHALL reset to all zeros.

Configuration
REQ-025 Macro FPU_DIVIDE_SPECIAL_BYPASS_EN, when defined: a captured input with nan, inf or zero set SHALL go from IDLE directly to DONE with y = 0 and A and b unchanged, giving out_valid 1 edge after the accepting edge.
REQ-026 Without FPU_DIVIDE_SPECIAL_BYPASS_EN: special inputs SHALL iterate like any other input, with latency ITERATIONS+1.

Verification
REQ-027 1.0/1.0: A = b = 2^49, flags clear -> after 28 edges out_valid = 1, y = 27'h4000000, A = 0.
REQ-028 1.5/1.0: A = 3*2^48, b = 2^49 -> y = 27'h6000000, A = 0.
REQ-029 1.0/1.5: A = 2^49, b = 3*2^48 -> y = 27'h2AAAAAA, A != 0, exponent/sign/mode echoed.
REQ-030 Backpressure: out_ready low 5 cycles in DONE -> out_data stable, in_ready 0, in_valid pulses ignored; out_ready high -> IDLE next edge.
REQ-031 rst asserted at step 10 of ITER -> next cycle IDLE, out_valid 0; next input completes with correct latency.
REQ-032 zero = 1 input: with FPU_DIVIDE_SPECIAL_BYPASS_EN -> out_valid after 1 edge, y = 0; without -> out_valid after 28 edges, zero = 1 echoed.
